// File: rtl/mc_pkg.sv
// Shared constants and helpers for the MC prediction write path.
//   SIZE_04/08/16 : block size codes driven on the FME/pred buffer write port
//   f_rows/f_segs/f_wpb/f_nblk : derived geometry of the packer
//   f_siz         : size code for a given block width
//   deint         : collects the even bits of a z-order index (x coordinate);
//                   pass index>>1 to get the odd bits (y coordinate)
package mc_pkg;

  localparam logic [1:0] SIZE_04 = 2'b00;
  localparam logic [1:0] SIZE_08 = 2'b01;
  localparam logic [1:0] SIZE_16 = 2'b10;

  // pixel rows of a block covered by one output word
  function automatic int f_rows(input int out_pix, input int blk_w);
    return out_pix / blk_w;
  endfunction

  // segments per output word
  function automatic int f_segs(input int out_pix, input int seg_pix);
    return out_pix / seg_pix;
  endfunction

  // output words per block
  function automatic int f_wpb(input int blk_w, input int out_pix);
    return (blk_w * blk_w) / out_pix;
  endfunction

  // blocks per CTU
  function automatic int f_nblk(input int ctu_w, input int blk_w);
    return (ctu_w / blk_w) * (ctu_w / blk_w);
  endfunction

  function automatic logic [1:0] f_siz(input int blk_w);
    case (blk_w)
      4:       return SIZE_04;
      16:      return SIZE_16;
      default: return SIZE_08;
    endcase
  endfunction

  function automatic logic [3:0] deint(input logic [7:0] v);
    logic [3:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) d[i] = v[2*i];
    return d;
  endfunction

endpackage

// File: rtl/mc_pred_pack_addr.sv
// Word/block counters and z-order address generation for the pred buffer
// write port.
//   clk, rst : clock, synchronous active-high reset
//   clr      : start of a new CTU, zeroes both counters
//   adv      : output word handshake, steps to the next word
//   x, y     : block position in 4x4 units
//   idx      : first block row carried by the current word
//   last     : current word is the final word of the CTU
module mc_pred_pack_addr
  import mc_pkg::*;
#(
  parameter int OUT_PIX = 32,
  parameter int BLK_W   = 8,
  parameter int CTU_W   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [4:0] idx,
  output logic       last
);

  localparam int ROWS = f_rows(OUT_PIX, BLK_W);
  localparam int WPB  = f_wpb(BLK_W, OUT_PIX);
  localparam int NBLK = f_nblk(CTU_W, BLK_W);
  localparam int WW   = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  logic [WW-1:0] word_cnt;
  logic [BW-1:0] blk_cnt;
  logic          word_last, blk_last;
  logic [7:0]    blk_ext;

  assign word_last = (word_cnt == WW'(WPB - 1));
  assign blk_last  = (blk_cnt == BW'(NBLK - 1));
  assign last      = word_last && blk_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word_cnt <= '0;
      blk_cnt  <= '0;
    end else if (adv) begin
      word_cnt <= word_last ? '0 : word_cnt + WW'(1);
      if (word_last) blk_cnt <= blk_last ? '0 : blk_cnt + BW'(1);
    end
  end

  // blk_cnt is a z-order index: even bits form x, odd bits form y
  assign blk_ext = 8'(blk_cnt);
  assign x   = 4'(int'(deint(blk_ext)) * (BLK_W / 4));
  assign y   = 4'(int'(deint(blk_ext >> 1)) * (BLK_W / 4));
  assign idx = 5'(int'(word_cnt) * ROWS);

endmodule

// File: rtl/mc_pred_pack.sv
// Chroma MC prediction write packer. Gathers SEG_PIX-pixel segments from the
// interpolator's one-hot lane bus into OUT_PIX-pixel words and drives them to
// the FME/pred buffer write port with z-order block addressing.
//   clk, rst            : clock, synchronous active-high reset
//   start_i / done_o    : CTU start, pulse on handshake of the CTU's last word
//   err_o               : sticky multi-hot lane enable flag
//   pred_ena_i/dat_i/rdy_o : segment input (lane 0 in the MSB slot)
//   wr_vld_o / wr_rdy_i : output word handshake
//   wr_siz_o, wr_4x4_x_o, wr_4x4_y_o, wr_idx_o, wr_dat_o : word address/data
module mc_pred_pack
  import mc_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int LANES       = 4,
  parameter int SEG_PIX     = 4,
  parameter int OUT_PIX     = 32,
  parameter int BLK_W       = 8,
  parameter int CTU_W       = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  output logic                               done_o,
  output logic                               err_o,
  input  logic [LANES-1:0]                   pred_ena_i,
  input  logic [LANES*SEG_PIX*PIXEL_WIDTH-1:0] pred_dat_i,
  output logic                               pred_rdy_o,
  output logic                               wr_vld_o,
  input  logic                               wr_rdy_i,
  output logic [1:0]                         wr_siz_o,
  output logic [3:0]                         wr_4x4_x_o,
  output logic [3:0]                         wr_4x4_y_o,
  output logic [4:0]                         wr_idx_o,
  output logic [OUT_PIX*PIXEL_WIDTH-1:0]     wr_dat_o
);

  localparam int SEG_W  = SEG_PIX * PIXEL_WIDTH;
  localparam int WORD_W = OUT_PIX * PIXEL_WIDTH;
  localparam int ROWS   = f_rows(OUT_PIX, BLK_W);
  localparam int SEGS   = f_segs(OUT_PIX, SEG_PIX);
  localparam int SCW    = (SEGS > 1) ? $clog2(SEGS) : 1;

  logic [LANES-1:0][SEG_W-1:0] lane_dat;
  logic [SEG_W-1:0]            seg;
  logic [SCW-1:0]              seg_cnt, slot;
  logic [WORD_W-1:0]           acc, acc_nxt;
  logic                        multi, accept, hs, word_done, last;

  assign lane_dat = pred_dat_i;

  // highest enabled lane wins when the enable is not one-hot
  always_comb begin
    seg = '0;
    for (int l = 0; l < LANES; l++)
      if (pred_ena_i[l]) seg = lane_dat[LANES-1-l];
  end

  assign multi = |(pred_ena_i & (pred_ena_i - LANES'(1)));

  // stall only when completing a word while the previous one is still held
  assign pred_rdy_o = !(wr_vld_o && !wr_rdy_i && seg_cnt == SCW'(SEGS - 1));
  assign accept     = (|pred_ena_i) && pred_rdy_o;
  assign hs         = wr_vld_o && wr_rdy_i;
  // a segment arriving with start_i is slot 0 of the new CTU
  assign slot       = start_i ? '0 : seg_cnt;
  assign word_done  = accept && !start_i && (seg_cnt == SCW'(SEGS - 1));

  // segment k: column k/ROWS, row k%ROWS of the word's pixel raster
  always_comb begin
    acc_nxt = start_i ? '0 : acc;
    for (int k = 0; k < SEGS; k++)
      if (accept && slot == SCW'(k))
        acc_nxt[WORD_W - PIXEL_WIDTH*((k % ROWS)*BLK_W + (k / ROWS)*SEG_PIX) - 1 -: SEG_W] = seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_cnt  <= '0;
      acc      <= '0;
      wr_vld_o <= 1'b0;
      wr_dat_o <= '0;
      err_o    <= 1'b0;
    end else begin
      if (start_i)    err_o <= multi;
      else if (multi) err_o <= 1'b1;

      if (word_done) begin
        acc      <= '0;
        seg_cnt  <= '0;
        wr_vld_o <= 1'b1;
        wr_dat_o <= acc_nxt;
      end else begin
        acc <= acc_nxt;
        if (accept)       seg_cnt <= slot + SCW'(1);
        else if (start_i) seg_cnt <= '0;
        if (start_i || hs) wr_vld_o <= 1'b0;
      end
    end
  end

  mc_pred_pack_addr #(
    .OUT_PIX (OUT_PIX),
    .BLK_W   (BLK_W),
    .CTU_W   (CTU_W)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_i),
    .adv  (hs),
    .x    (wr_4x4_x_o),
    .y    (wr_4x4_y_o),
    .idx  (wr_idx_o),
    .last (last)
  );

  assign done_o   = hs && last && !rst && !start_i;
  assign wr_siz_o = f_siz(BLK_W);

endmodule

// File: tb/tb_mc_pred_pack.sv
// Bench for mc_pred_pack: a default instance (BLK_W=8) and a BLK_W=16
// instance share one stimulus stream; a pixel-level reference model checks
// both every cycle, plus directed sequences for stall, multi-hot, restart
// and reset corners.
module tb_mc_pred_pack;
  import mc_pkg::*;

  logic         clk = 1'b0;
  logic         rst, start_i, wr_rdy_i;
  logic [3:0]   pred_ena_i;
  logic [127:0] pred_dat_i;
  logic         done_o [2];
  logic         err_o [2];
  logic         pred_rdy_o [2];
  logic         wr_vld_o [2];
  logic [1:0]   wr_siz_o [2];
  logic [3:0]   wr_x [2];
  logic [3:0]   wr_y [2];
  logic [4:0]   wr_idx [2];
  logic [255:0] wr_dat [2];

  always #5 clk = ~clk;

  mc_pred_pack dut0 (
    .clk(clk), .rst(rst), .start_i(start_i), .done_o(done_o[0]), .err_o(err_o[0]),
    .pred_ena_i(pred_ena_i), .pred_dat_i(pred_dat_i), .pred_rdy_o(pred_rdy_o[0]),
    .wr_vld_o(wr_vld_o[0]), .wr_rdy_i(wr_rdy_i), .wr_siz_o(wr_siz_o[0]),
    .wr_4x4_x_o(wr_x[0]), .wr_4x4_y_o(wr_y[0]), .wr_idx_o(wr_idx[0]), .wr_dat_o(wr_dat[0]));

  mc_pred_pack #(.BLK_W(16), .CTU_W(32)) dut1 (
    .clk(clk), .rst(rst), .start_i(start_i), .done_o(done_o[1]), .err_o(err_o[1]),
    .pred_ena_i(pred_ena_i), .pred_dat_i(pred_dat_i), .pred_rdy_o(pred_rdy_o[1]),
    .wr_vld_o(wr_vld_o[1]), .wr_rdy_i(wr_rdy_i), .wr_siz_o(wr_siz_o[1]),
    .wr_4x4_x_o(wr_x[1]), .wr_4x4_y_o(wr_y[1]), .wr_idx_o(wr_idx[1]), .wr_dat_o(wr_dat[1]));

  int checks = 0;
  int failures = 0;

  // reference model state: segments of the word in progress, one held word
  int           m_cnt [2];
  bit           m_vld [2];
  bit           m_err [2];
  int           m_issued [2];
  logic [255:0] m_word [2];
  logic [31:0]  m_seg [2][8];

  // observed handshakes
  logic [255:0] wlog0[$], wlog1[$];
  logic [12:0]  alog0[$], alog1[$];
  int           hs_n [2];
  int           done_cnt [2];
  int           done_hs [2];

  typedef struct {
    logic [3:0] ena;
    int         lane;
    bit         err;
  } vec_t;

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic int bw_of(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  // pixel i of the word sits at block row i/bw, column i%bw; that column
  // belongs to segment (column/4)*rows + row
  function automatic logic [255:0] build(input int d);
    int bw, rows, r, c, k, j;
    logic [255:0] w;
    bw = bw_of(d);
    rows = 32 / bw;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      r = i / bw;
      c = i % bw;
      k = (c / 4) * rows + r;
      j = c % 4;
      w[255-8*i -: 8] = m_seg[d][k][31-8*j -: 8];
    end
    return w;
  endfunction

  function automatic logic [12:0] addr_of(input int d, input int n);
    int bw, wpb, nb, blk, wc, x, y;
    bw = bw_of(d);
    wpb = bw * bw / 32;
    nb = (32 / bw) * (32 / bw);
    blk = (n / wpb) % nb;
    wc = n % wpb;
    x = 0;
    y = 0;
    for (int b = 0; b < 4; b++) begin
      x += ((blk >> (2*b)) & 1) << b;
      y += ((blk >> (2*b+1)) & 1) << b;
    end
    x = x * bw / 4;
    y = y * bw / 4;
    return {x[3:0], y[3:0], 5'(wc * (32 / bw))};
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_vld[d] = 0; m_err[d] = 0; m_issued[d] = 0; m_word[d] = '0;
    end
  endtask

  task automatic clear_logs();
    wlog0.delete(); wlog1.delete(); alog0.delete(); alog1.delete();
    for (int d = 0; d < 2; d++) begin
      hs_n[d] = 0; done_cnt[d] = 0; done_hs[d] = 0;
    end
  endtask

  // compare one DUT against the model for the current cycle, then advance
  task automatic model(input int d, input logic [3:0] ena, input logic [127:0] dat,
                       input bit rdy, input bit st, input bit rs, output bit acc);
    bit hs, exp_rdy, multi, exp_done;
    int lane, bw, tot;
    logic [31:0] seg;
    bw = bw_of(d);
    tot = (bw * bw / 32) * (32 / bw) * (32 / bw);
    exp_rdy = !(m_vld[d] && !rdy && m_cnt[d] == 7);
    check($sformatf("rdy%0d", d), pred_rdy_o[d], exp_rdy);
    check($sformatf("vld%0d", d), wr_vld_o[d], m_vld[d]);
    check($sformatf("err%0d", d), err_o[d], m_err[d]);
    check($sformatf("siz%0d", d), wr_siz_o[d], (d == 0) ? SIZE_08 : SIZE_16);
    if (m_vld[d]) begin
      check($sformatf("dat%0d", d), wr_dat[d], m_word[d]);
      check($sformatf("addr%0d", d), {wr_x[d], wr_y[d], wr_idx[d]}, addr_of(d, m_issued[d]));
    end
    hs = m_vld[d] && rdy;
    exp_done = hs && ((m_issued[d] + 1) % tot == 0) && !rs && !st;
    check($sformatf("done%0d", d), done_o[d], exp_done);
    if (hs && !rs && !st) begin
      if (d == 0) begin wlog0.push_back(wr_dat[0]); alog0.push_back({wr_x[0], wr_y[0], wr_idx[0]}); end
      else        begin wlog1.push_back(wr_dat[1]); alog1.push_back({wr_x[1], wr_y[1], wr_idx[1]}); end
      hs_n[d]++;
      if (done_o[d]) begin done_cnt[d]++; done_hs[d] = hs_n[d]; end
    end
    multi = ($countones(ena) > 1);
    lane = 0;
    for (int l = 0; l < 4; l++) if (ena[l]) lane = l;
    seg = dat[127-32*lane -: 32];
    acc = (ena != 0) && exp_rdy && !rs;
    if (rs) begin
      m_cnt[d] = 0; m_vld[d] = 0; m_err[d] = 0; m_issued[d] = 0;
    end else begin
      if (st) begin
        m_cnt[d] = 0; m_vld[d] = 0; m_issued[d] = 0; m_err[d] = 0;
      end else if (hs) begin
        m_vld[d] = 0; m_issued[d]++;
      end
      if (multi) m_err[d] = 1;
      if (acc) begin
        m_seg[d][m_cnt[d]] = seg;
        m_cnt[d]++;
        if (m_cnt[d] == 8) begin
          m_word[d] = build(d);
          m_vld[d] = 1;
          m_cnt[d] = 0;
        end
      end
    end
  endtask

  // one clock: drive after the edge, check at the falling edge
  task automatic step(input logic [3:0] ena, input logic [127:0] dat, input bit rdy,
                      input bit st, input bit rs, output bit acc0);
    bit a1;
    pred_ena_i = ena; pred_dat_i = dat; wr_rdy_i = rdy; start_i = st; rst = rs;
    @(negedge clk);
    model(0, ena, dat, rdy, st, rs, acc0);
    model(1, ena, dat, rdy, st, rs, a1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] ena, input logic [127:0] dat, input bit rdy);
    bit a;
    int n;
    n = 0;
    a = 0;
    while (!a && n < 40) begin
      step(ena, dat, rdy, 0, 0, a);
      n++;
    end
    if (!a) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input bit rdy, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(4'b0000, '0, rdy, 0, 0, a);
  endtask

  function automatic logic [127:0] segv(input int v);
    return {$urandom(), $urandom(), $urandom(), {4{8'(v)}}};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t         tbl [8];
    bit           a;
    int           p, r;
    logic [127:0] dv;
    logic [3:0]   ena;
    logic [255:0] w;

    tbl[0] = '{4'b1000, 3, 1'b0};
    tbl[1] = '{4'b0001, 0, 1'b0};
    tbl[2] = '{4'b0101, 2, 1'b1};
    tbl[3] = '{4'b0010, 1, 1'b1};
    tbl[4] = '{4'b1100, 3, 1'b1};
    tbl[5] = '{4'b0100, 2, 1'b1};
    tbl[6] = '{4'b1111, 3, 1'b1};
    tbl[7] = '{4'b0001, 0, 1'b1};

    rst = 1; start_i = 0; wr_rdy_i = 0; pred_ena_i = '0; pred_dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    clear_logs();
    for (int d = 0; d < 2; d++) begin
      check("rst_vld", wr_vld_o[d], 0);
      check("rst_err", err_o[d], 0);
      check("rst_addr", {wr_x[d], wr_y[d], wr_idx[d]}, 0);
      check("rst_dat", wr_dat[d], 0);
    end

    // full CTU on lane 3, pixel value = segment index
    step(4'b0000, '0, 1, 1, 0, a);
    clear_logs();
    for (int k = 0; k < 256; k++) send(4'b1000, segv(k), 1);
    idle(1, 3);
    check("t1_words0", wlog0.size(), 32);
    check("t1_words1", wlog1.size(), 32);
    check("t1_addr0", alog0[0], 13'd0);
    check("t1_seg0", wlog0[0][255:224], 32'h00000000);
    check("t1_seg4", wlog0[0][223:192], 32'h04040404);
    check("t1_idx1", alog0[1][4:0], 5'd4);
    check("t1_done0", done_hs[0], 32);
    check("t1_ndone0", done_cnt[0], 1);
    check("t5_siz", wr_siz_o[1], 2'b10);
    check("t5_idx1", alog1[1][4:0], 5'd2);
    check("t5_blk1", alog1[8], {4'd4, 4'd0, 5'd0});
    check("t5_done1", done_hs[1], 32);
    check("t5_ndone1", done_cnt[1], 1);

    // sink stall with the next word filling behind it
    step(4'b0000, '0, 1, 1, 0, a);
    clear_logs();
    for (int k = 0; k < 15; k++) send(4'b1000, segv(k), 0);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, segv(15), 0, 0, 0, a);
      check("t2_acc", a, 0);
      check("t2_rdy", pred_rdy_o[0], 0);
      check("t2_vld", wr_vld_o[0], 1);
      check("t2_hold0", wr_dat[0][255:224], 32'h00000000);
      check("t2_hold4", wr_dat[0][223:192], 32'h04040404);
    end
    send(4'b1000, segv(15), 1);
    check("t2_w1_vld", wr_vld_o[0], 1);
    check("t2_w1_seg0", wr_dat[0][255:224], 32'h08080808);
    for (int k = 16; k < 24; k++) send(4'b1000, segv(k), 1);
    idle(1, 3);
    check("t2_words", wlog0.size(), 3);
    check("t2_w1", wlog0[1][223:192], 32'h0c0c0c0c);
    check("t2_w2", wlog0[2][255:224], 32'h10101010);

    // lane select table including multi-hot enables
    step(4'b0000, '0, 1, 1, 0, a);
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      dv = '0;
      for (int l = 0; l < 4; l++) dv[127-32*l -: 32] = {4{4'(l), 4'(i)}};
      send(tbl[i].ena, dv, 1);
      check($sformatf("t3_err%0d", i), err_o[0], tbl[i].err);
    end
    idle(1, 2);
    w = wlog0[0];
    for (int k = 0; k < 8; k++) begin
      p = (k % 4) * 8 + (k / 4) * 4;
      check($sformatf("t3_lane%0d", k), w[255-8*p -: 32], {4{4'(tbl[k].lane), 4'(k)}});
    end
    for (int k = 0; k < 4; k++) send(4'b0010, segv(k), 1);
    check("t3_sticky", err_o[0], 1);
    step(4'b0000, '0, 1, 1, 0, a);
    check("t3_clr", err_o[0], 0);

    // restart after a partial word
    clear_logs();
    for (int k = 0; k < 5; k++) send(4'b1000, segv(100 + k), 1);
    step(4'b0000, '0, 1, 1, 0, a);
    for (int k = 0; k < 8; k++) send(4'b1000, segv(200 + k), 1);
    idle(1, 2);
    check("t4_words", wlog0.size(), 1);
    check("t4_addr", alog0[0], 13'd0);
    check("t4_seg0", wlog0[0][255:224], {4{8'd200}});

    // reset while the CTU's last word is held
    step(4'b0000, '0, 1, 1, 0, a);
    clear_logs();
    for (int k = 0; k < 248; k++) send(4'b1000, segv(k), 1);
    idle(1, 2);
    for (int k = 248; k < 256; k++) send(4'b1000, segv(k), 0);
    step(4'b0000, '0, 0, 0, 0, a);
    check("t6_vld", wr_vld_o[0], 1);
    check("t6_lastidx", wr_idx[0], 5'd4);
    step(4'b0000, '0, 1, 0, 1, a);
    for (int d = 0; d < 2; d++) begin
      check("t6_vld0", wr_vld_o[d], 0);
      check("t6_done0", done_o[d], 0);
      check("t6_err0", err_o[d], 0);
      check("t6_addr0", {wr_x[d], wr_y[d], wr_idx[d]}, 0);
      check("t6_dat0", wr_dat[d], 0);
    end
    check("t6_nodone", done_cnt[0], 0);

    // randomized traffic against the model
    step(4'b0000, '0, 1, 1, 0, a);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      ena = 4'b0000;
      else if (r < 20) ena = 4'($urandom_range(1, 15));
      else             ena = 4'(1 << $urandom_range(0, 3));
      step(ena, {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0, 0, a);
    end
    idle(1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
